// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the pixel loader.
package nn_pkg;
   localparam int N_IN         = 784;
   localparam int PIX_PER_WORD = 4;
   localparam int PIX_ADDR_W   = 10;
   localparam int LANE_IDX_W   = $clog2(PIX_PER_WORD);

   typedef enum logic [2:0] {IDLE, UNPACK, LOADED, START, WAIT} st_e;
endpackage

// File: rtl/nn_pix_loader_if.sv
// Word-in / pixel-out / core-control bundle between the register block, loader and core.
interface nn_pix_loader_if;
   import nn_pkg::*;

   logic                  wr_valid;
   logic [31:0]           wr_data;
   logic                  wr_ready;
   logic                  pix_we;
   logic [PIX_ADDR_W-1:0] pix_addr;
   logic [7:0]            pix_data;
   logic                  start;
   logic                  done;
   logic [3:0]            predicted;

   modport slave  (input  wr_valid, wr_data, done, predicted,
                   output wr_ready, pix_we, pix_addr, pix_data, start);
   modport master (output wr_valid, wr_data, done, predicted,
                   input  wr_ready, pix_we, pix_addr, pix_data, start);
endinterface

// File: rtl/nn_word_unpack.sv
// Holds one packed word and walks its byte lanes (lane 0 first) while
// advancing the image-wide pixel address.
module nn_word_unpack
   import nn_pkg::*;
#(
   parameter int N_IN = nn_pkg::N_IN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [31:0]           word,
   input  logic                  step,
   input  logic                  clr,
   output logic [PIX_ADDR_W-1:0] addr,
   output logic [7:0]            data,
   output logic                  last_byte,
   output logic                  last_pix,
   output logic                  cnt_zero
);
   logic [PIX_PER_WORD-1:0][7:0] lanes;
   logic [LANE_IDX_W-1:0]        idx;
   logic [PIX_ADDR_W-1:0]        cnt;

   // Word/lane register and pixel counter; the counter parks on the last
   // pixel so the address never runs past the image.
   always_ff @(posedge clk) begin
      if (rst) begin
         lanes <= '0;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         if (load) begin
            lanes <= word;
            idx   <= '0;
         end else if (step) begin
            idx <= idx + 1'b1;
         end
         if (clr)
            cnt <= '0;
         else if (step && !last_pix)
            cnt <= cnt + 1'b1;
      end
   end

   assign addr      = cnt;
   assign data      = lanes[idx];
   assign last_byte = (idx == LANE_IDX_W'(PIX_PER_WORD - 1));
   assign last_pix  = (cnt == PIX_ADDR_W'(N_IN - 1));
   assign cnt_zero  = (cnt == '0);
endmodule

// File: rtl/nn_pix_loader.sv
// Loads one image into the inference core a byte per cycle, launches it and
// captures the class result with a completion timeout.
module nn_pix_loader
   import nn_pkg::*;
#(
   parameter int N_IN    = nn_pkg::N_IN,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   nn_pix_loader_if.slave bus,
   input  logic           ctrl_go,
   input  logic           ctrl_clear,
   output logic           busy,
   output logic           loaded,
   output logic [3:0]     result,
   output logic           result_valid,
   output logic           err_go_early,
   output logic           err_timeout
);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   st_e             st, nxt;
   logic [TMR_W-1:0] tmr;
   logic            accept, tmr_last, cnt_clr;
   logic            last_byte, last_pix, cnt_zero;

   assign accept   = bus.wr_valid & bus.wr_ready & ~ctrl_clear;
   assign tmr_last = (tmr == TMR_W'(TIMEOUT - 1));
   assign cnt_clr  = ctrl_clear | ((st == WAIT) & (bus.done | tmr_last));

   nn_word_unpack #(.N_IN(N_IN)) u_unpack (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .word      (bus.wr_data),
      .step      (st == UNPACK),
      .clr       (cnt_clr),
      .addr      (bus.pix_addr),
      .data      (bus.pix_data),
      .last_byte (last_byte),
      .last_pix  (last_pix),
      .cnt_zero  (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= nxt;
   end

   // Next state and state-decoded outputs; clear overrides every transition.
   always_comb begin
      nxt          = st;
      bus.wr_ready = 1'b0;
      bus.pix_we   = 1'b0;
      bus.start    = 1'b0;
      busy         = 1'b1;
      loaded       = 1'b0;
      case (st)
         IDLE: begin
            bus.wr_ready = 1'b1;
            busy         = 1'b0;
            if (bus.wr_valid) nxt = UNPACK;
         end
         UNPACK: begin
            bus.pix_we = 1'b1;
            if (last_pix)       nxt = LOADED;
            else if (last_byte) nxt = IDLE;
         end
         LOADED: begin
            busy   = 1'b0;
            loaded = 1'b1;
            if (ctrl_go) nxt = START;
         end
         START: begin
            bus.start = 1'b1;
            nxt       = WAIT;
         end
         WAIT: begin
            if (bus.done || tmr_last) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
      if (ctrl_clear) nxt = IDLE;
   end

   // Completion timer, sticky result/error flags; a new image wipes the flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         err_go_early <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (st == START)     tmr <= '0;
         else if (st == WAIT) tmr <= tmr + 1'b1;
         if (accept && cnt_zero) begin
            result_valid <= 1'b0;
            err_go_early <= 1'b0;
            err_timeout  <= 1'b0;
         end
         if (ctrl_go && !ctrl_clear && st != LOADED)
            err_go_early <= 1'b1;
         if (st == WAIT && !ctrl_clear) begin
            if (bus.done) begin
               result       <= bus.predicted;
               result_valid <= 1'b1;
            end else if (tmr_last) begin
               err_timeout <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_nn_pix_loader.sv
// Directed bench: a queue model of the expected pixel stream is checked on
// every write strobe, plus literal expectations per scenario.
module tb_nn_pix_loader;
   localparam int NPIX = 784;
   localparam int TMO  = 1024;

   logic       clk = 1'b0, rst = 1'b1, ctrl_go = 1'b0, ctrl_clear = 1'b0;
   logic       busy, loaded, result_valid, err_go_early, err_timeout;
   logic [3:0] result;

   nn_pix_loader_if bus ();

   nn_pix_loader #(.N_IN(NPIX), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .ctrl_go      (ctrl_go),
      .ctrl_clear   (ctrl_clear),
      .busy         (busy),
      .loaded       (loaded),
      .result       (result),
      .result_valid (result_valid),
      .err_go_early (err_go_early),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model state: expected pixel writes derived from accepted words.
   typedef struct { int addr; int data; } wr_t;
   wr_t  exp_q[$];
   int   mdl_cnt = 0, acc_cnt = 0;
   int   n_wr = 0, n_start = 0, n_busy = 0, n_rdy = 0, n_rv = 0;
   int   last_addr = -1, last_data = -1, last_rv_res = -1;
   logic       core_en = 1'b0;
   logic [3:0] core_pred = '0;

   // Compare process: mid-cycle, check the current write, then account for
   // a handshake or clear that the coming edge will act on.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.pix_we) begin : pop
            wr_t e;
            n_wr++;
            last_addr = int'(bus.pix_addr);
            last_data = int'(bus.pix_data);
            check("pix_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("pix_addr", bus.pix_addr, e.addr);
               check("pix_data", bus.pix_data, e.data);
            end
         end
         if (bus.start)    n_start++;
         if (busy)         n_busy++;
         if (bus.wr_ready) n_rdy++;
         if (result_valid) begin
            n_rv++;
            last_rv_res = int'(result);
         end
         if (ctrl_clear) begin
            exp_q.delete();
            mdl_cnt = 0;
         end else if (bus.wr_valid && bus.wr_ready) begin
            acc_cnt++;
            for (int k = 0; k < 4; k++)
               exp_q.push_back('{addr: mdl_cnt + k, data: int'(bus.wr_data[8*k +: 8])});
            mdl_cnt += 4;
            if (mdl_cnt == NPIX) mdl_cnt = 0;
         end
      end
   end

   // Core stand-in: done with the class two cycles after start.
   initial begin
      bus.done      = 1'b0;
      bus.predicted = '0;
      forever begin
         @(negedge clk);
         if (bus.start && core_en) begin
            repeat (2) @(posedge clk);
            #1;
            bus.done      = 1'b1;
            bus.predicted = core_pred;
            @(posedge clk);
            #1;
            bus.done      = 1'b0;
            bus.predicted = '0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input int n, input logic [31:0] w);
      int tgt, guard;
      tgt = acc_cnt + n;
      guard = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = w;
      while (acc_cnt < tgt && guard < 8*n + 20) begin
         tick();
         guard++;
      end
      bus.wr_valid = 1'b0;
      check("send_words_accepted", acc_cnt, tgt);
   endtask

   task automatic pulse_go();
      ctrl_go = 1'b1;
      tick();
      ctrl_go = 1'b0;
   endtask

   task automatic wait_loaded(input string name, input int budget);
      int g;
      g = 0;
      while (!loaded && g < budget) begin
         tick();
         g++;
      end
      check(name, loaded, 1);
   endtask

   task automatic wait_not_busy(input string name, input int budget);
      int g;
      g = 0;
      while (busy && g < budget) begin
         tick();
         g++;
      end
      check(name, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, b0, w0, r0, v0, a0, g;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      repeat (3) tick();
      check("rst_pix_we", bus.pix_we, 0);
      check("rst_start", bus.start, 0);
      check("rst_busy", busy, 0);
      check("rst_loaded", loaded, 0);
      check("rst_result", result, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_err_go_early", err_go_early, 0);
      check("rst_err_timeout", err_timeout, 0);
      rst = 1'b0;
      tick();
      check("idle_wr_ready", bus.wr_ready, 1);

      // 1: full image of 0,1,2,3 pattern
      send_words(196, 32'h03020100);
      wait_loaded("t1_loaded", 10);
      check("t1_writes", n_wr, 784);
      check("t1_last_addr", last_addr, 783);
      check("t1_last_data", last_data, 3);
      check("t1_busy", busy, 0);
      check("t1_wr_ready", bus.wr_ready, 0);
      check("t1_q_empty", exp_q.size(), 0);

      // 2: go, core answers 7
      s0 = n_start; b0 = n_busy;
      core_en = 1'b1; core_pred = 4'd7;
      pulse_go();
      wait_not_busy("t2_done", 20);
      check("t2_start_cycles", n_start - s0, 1);
      check("t2_busy_cycles", n_busy - b0, 3);
      check("t2_result", result, 7);
      check("t2_result_valid", result_valid, 1);
      check("t2_loaded", loaded, 0);
      check("t2_err_timeout", err_timeout, 0);
      check("t2_err_go_early", err_go_early, 0);

      // 3: early go after 10 words
      s0 = n_start; w0 = n_wr;
      send_words(10, 32'hD0C0B0A0);
      check("t3_rv_cleared", result_valid, 0);
      pulse_go();
      check("t3_err_go_early", err_go_early, 1);
      send_words(186, 32'h44332211);
      wait_loaded("t3_loaded", 10);
      check("t3_no_start", n_start - s0, 0);
      check("t3_writes", n_wr - w0, 784);
      check("t3_err_go_early_kept", err_go_early, 1);
      check("t3_result_kept", result, 7);

      // 4: core silent -> timeout
      core_en = 1'b0; b0 = n_busy;
      pulse_go();
      wait_not_busy("t4_back_idle", 1100);
      check("t4_busy_cycles", n_busy - b0, 1025);
      check("t4_err_timeout", err_timeout, 1);
      check("t4_result_valid", result_valid, 0);
      check("t4_loaded", loaded, 0);
      check("t4_wr_ready", bus.wr_ready, 1);

      // 5: clear right after pixel 401
      w0 = n_wr;
      send_words(101, 32'h0F0E0D0C);
      check("t5_err_timeout_cleared", err_timeout, 0);
      check("t5_err_go_early_cleared", err_go_early, 0);
      tick();
      ctrl_clear = 1'b1;
      tick();
      ctrl_clear = 1'b0;
      check("t5_pix_we_dropped", bus.pix_we, 0);
      check("t5_busy", busy, 0);
      check("t5_wr_ready", bus.wr_ready, 1);
      check("t5_last_addr", last_addr, 401);
      check("t5_writes", n_wr - w0, 402);
      send_words(1, 32'h44332211);
      repeat (5) tick();
      check("t5_restart_addr", last_addr, 3);
      check("t5_restart_data", last_data, 'h44);
      check("t5_q_empty", exp_q.size(), 0);
      send_words(195, 32'h03020100);
      wait_loaded("t5_loaded", 10);

      // 6: back-pressure in LOADED, then new image clears result_valid
      w0 = n_wr; r0 = n_rdy;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'h0D0C0B0A;
      repeat (20) tick();
      check("t6_no_writes", n_wr - w0, 0);
      check("t6_no_ready", n_rdy - r0, 0);
      check("t6_loaded", loaded, 1);
      v0 = n_rv; a0 = acc_cnt;
      core_en = 1'b1; core_pred = 4'd10;
      pulse_go();
      g = 0;
      while (acc_cnt == a0 && g < 50) begin
         tick();
         g++;
      end
      bus.wr_valid = 1'b0;
      check("t6_accept", acc_cnt, a0 + 1);
      repeat (6) tick();
      check("t6_rv_pulse_cycles", n_rv - v0, 1);
      check("t6_rv_result", last_rv_res, 10);
      check("t6_result_valid_cleared", result_valid, 0);
      check("t6_result_kept", result, 10);
      check("t6_last_addr", last_addr, 3);
      check("t6_last_data", last_data, 'h0D);
      check("t6_writes", n_wr - w0, 4);
      check("t6_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
